// File: rtl/fpu_pkg.sv
// Shared constants, operand classes and format helpers for the streaming FP multiplier.
// Optional flags output of fpu_mult_stream is enabled by defining FPU_MULT_FLAGS_EN.
package fpu_pkg;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // What the product resolves to once both operand classes are known.
    typedef enum logic [1:0] {
        KIND_NUM,
        KIND_ZERO,
        KIND_INF,
        KIND_NAN
    } res_kind_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Encodings are returned in the low bits of a 64-bit word; callers slice to width.
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_max_finite(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fpu_mult_round.sv
// Combinational normalise, round, pack and special-case resolution for the multiplier's S3.
// Flag outputs exist only when FPU_MULT_FLAGS_EN is defined.
module fpu_mult_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     sign_i,
    input  res_kind_e                kind_i,
    input  logic                     rnd_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic [2*MAN_W+1:0]       prod_i,
`ifdef FPU_MULT_FLAGS_EN
    input  logic                     invalid_i,
    output logic [3:0]               flags_o,
`endif
    output logic [EXP_W+MAN_W:0]     result_o
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic [63:0]          QNAN64  = fp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]          MAXF64  = fp_max_finite(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN    = QNAN64[W-1:0];
    localparam logic [W-2:0]         MAXF    = MAXF64[W-2:0];
    localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_NIL = EW'(0);

    function automatic logic rne_inc(input logic rnd, input logic g, input logic s, input logic lsb);
        return (rnd == RND_RNE) && g && (s || lsb);
    endfunction

    // Out-of-range magnitude: RNE saturates to infinity, RTZ to the largest finite value.
    function automatic logic [W-1:0] sat_value(input logic sign, input logic rnd);
        if (rnd == RND_RNE)
            return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        return {sign, MAXF};
    endfunction

    logic [PW-1:0]         norm;
    logic [MAN_W:0]        mant;
    logic [MAN_W+1:0]      mant_r;
    logic [MAN_W-1:0]      frac_r;
    logic                  guard, sticky, carry, ovf, unf;
    logic signed [EW-1:0]  exp_n, exp_r;

    always_comb begin
        norm   = prod_i[PW-1] ? prod_i : {prod_i[PW-2:0], 1'b0};
        mant   = norm[PW-1 -: MAN_W+1];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        exp_n  = exp_i + (prod_i[PW-1] ? EXP_ONE : EXP_NIL);

        mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rne_inc(rnd_i, guard, sticky, mant[0])};
        carry  = mant_r[MAN_W+1];
        frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_r  = exp_n + (carry ? EXP_ONE : EXP_NIL);

        ovf = (exp_r >= EXP_TOP);
        unf = (exp_r <= EXP_NIL);

        result_o = {sign_i, {(W-1){1'b0}}};
        case (kind_i)
            KIND_NAN:  result_o = QNAN;
            KIND_INF:  result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            KIND_ZERO: result_o = {sign_i, {(W-1){1'b0}}};
            default: begin
                if (ovf)
                    result_o = sat_value(sign_i, rnd_i);
                else if (!unf)
                    result_o = {sign_i, exp_r[EXP_W-1:0], frac_r};
            end
        endcase
    end

`ifdef FPU_MULT_FLAGS_EN
    always_comb begin
        flags_o = '0;
        if (kind_i == KIND_NAN) begin
            flags_o[FLAG_INVALID] = invalid_i;
        end else if (kind_i == KIND_NUM) begin
            flags_o[FLAG_OVERFLOW]  = ovf;
            flags_o[FLAG_UNDERFLOW] = unf && !ovf;
            flags_o[FLAG_INEXACT]   = guard || sticky || ovf || unf;
        end
    end
`endif

endmodule

// File: rtl/fpu_mult_stream.sv
// Streaming IEEE-style multiplier with valid/ready handshake, bubble collapsing and RNE/RTZ.
// Define FPU_MULT_FLAGS_EN to add out_flags {invalid, overflow, underflow, inexact}.
module fpu_mult_stream
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MAN_W:0]  in_a,
    input  logic [EXP_W+MAN_W:0]  in_b,
    input  logic                  in_rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef FPU_MULT_FLAGS_EN
    output logic [3:0]            out_flags,
`endif
    output logic [EXP_W+MAN_W:0]  out_result
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

    function automatic fp_class_e classify(input logic [W-1:0] x);
        if (x[W-2 -: EXP_W] == '0)
            return (x[MAN_W-1:0] == '0) ? CLS_ZERO : CLS_SUB;
        if (x[W-2 -: EXP_W] == '1)
            return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    // inf*subnormal is still inf: the inf rule outranks flushing the subnormal.
    function automatic res_kind_e resolve_kind(input fp_class_e ca, input fp_class_e cb);
        if (ca == CLS_NAN || cb == CLS_NAN)
            return KIND_NAN;
        if ((ca == CLS_INF && cb == CLS_ZERO) || (cb == CLS_INF && ca == CLS_ZERO))
            return KIND_NAN;
        if (ca == CLS_INF || cb == CLS_INF)
            return KIND_INF;
        if (ca == CLS_NORM && cb == CLS_NORM)
            return KIND_NUM;
        return KIND_ZERO;
    endfunction

    logic [STAGES-1:0] adv, v_d, v_q;
    fp_class_e         cls_a, cls_b;

    logic                  sign_p0_d, sign_p0_q, rnd_p0_d, rnd_p0_q;
    res_kind_e             kind_p0_d, kind_p0_q;
    logic signed [EW-1:0]  exp_p0_d, exp_p0_q;
    logic [MAN_W:0]        man_a_p0_d, man_a_p0_q, man_b_p0_d, man_b_p0_q;

    logic                  sign_p1_d, sign_p1_q, rnd_p1_d, rnd_p1_q;
    res_kind_e             kind_p1_d, kind_p1_q;
    logic signed [EW-1:0]  exp_p1_d, exp_p1_q;
    logic [PW-1:0]         prod_p1_d, prod_p1_q;

    logic [W-1:0]          rnd_result;
    logic [W-1:0]          res_d [2:STAGES-1];
    logic [W-1:0]          res_q [2:STAGES-1];

`ifdef FPU_MULT_FLAGS_EN
    function automatic logic is_snan(input logic [W-1:0] x);
        return (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0) && !x[MAN_W-1];
    endfunction

    logic                  invalid_p0_d, invalid_p0_q, invalid_p1_d, invalid_p1_q;
    logic [3:0]            rnd_flags;
    logic [3:0]            flags_d [2:STAGES-1];
    logic [3:0]            flags_q [2:STAGES-1];
`endif

    // A stage may advance when it is empty or anything downstream can drain.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready || !(&v_q[STAGES-1:k]);
    end

    assign in_ready = adv[0];
    assign cls_a    = classify(in_a);
    assign cls_b    = classify(in_b);

    always_comb begin
        v_d[0] = adv[0] ? in_valid : v_q[0];
        for (int k = 1; k < STAGES; k++)
            v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
    end

    // ---- S1: unpack, classify, sign and biased exponent sum ----
    always_comb begin
        sign_p0_d  = sign_p0_q;
        rnd_p0_d   = rnd_p0_q;
        kind_p0_d  = kind_p0_q;
        exp_p0_d   = exp_p0_q;
        man_a_p0_d = man_a_p0_q;
        man_b_p0_d = man_b_p0_q;
        if (in_valid && adv[0]) begin
            sign_p0_d  = in_a[W-1] ^ in_b[W-1];
            rnd_p0_d   = in_rnd;
            kind_p0_d  = resolve_kind(cls_a, cls_b);
            exp_p0_d   = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS;
            man_a_p0_d = {1'b1, in_a[MAN_W-1:0]};
            man_b_p0_d = {1'b1, in_b[MAN_W-1:0]};
        end
    end

    // ---- S2: significand product ----
    always_comb begin
        sign_p1_d = sign_p1_q;
        rnd_p1_d  = rnd_p1_q;
        kind_p1_d = kind_p1_q;
        exp_p1_d  = exp_p1_q;
        prod_p1_d = prod_p1_q;
        if (v_q[0] && adv[1]) begin
            sign_p1_d = sign_p0_q;
            rnd_p1_d  = rnd_p0_q;
            kind_p1_d = kind_p0_q;
            exp_p1_d  = exp_p0_q;
            prod_p1_d = {{(MAN_W+1){1'b0}}, man_a_p0_q} * {{(MAN_W+1){1'b0}}, man_b_p0_q};
        end
    end

    // ---- S3: normalise, round, pack; later stages are plain delay ----
    fpu_mult_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i    (sign_p1_q),
        .kind_i    (kind_p1_q),
        .rnd_i     (rnd_p1_q),
        .exp_i     (exp_p1_q),
        .prod_i    (prod_p1_q),
`ifdef FPU_MULT_FLAGS_EN
        .invalid_i (invalid_p1_q),
        .flags_o   (rnd_flags),
`endif
        .result_o  (rnd_result)
    );

    always_comb begin
        res_d = res_q;
        if (v_q[1] && adv[2])
            res_d[2] = rnd_result;
        for (int k = 3; k < STAGES; k++)
            if (v_q[k-1] && adv[k])
                res_d[k] = res_q[k-1];
    end

`ifdef FPU_MULT_FLAGS_EN
    always_comb begin
        invalid_p0_d = invalid_p0_q;
        invalid_p1_d = invalid_p1_q;
        flags_d      = flags_q;
        if (in_valid && adv[0])
            invalid_p0_d = is_snan(in_a) || is_snan(in_b) ||
                           (resolve_kind(cls_a, cls_b) == KIND_NAN && cls_a != CLS_NAN && cls_b != CLS_NAN);
        if (v_q[0] && adv[1])
            invalid_p1_d = invalid_p0_q;
        if (v_q[1] && adv[2])
            flags_d[2] = rnd_flags;
        for (int k = 3; k < STAGES; k++)
            if (v_q[k-1] && adv[k])
                flags_d[k] = flags_q[k-1];
    end

    always_ff @(posedge clk) begin
        invalid_p0_q <= invalid_p0_d;
        invalid_p1_q <= invalid_p1_d;
        flags_q      <= flags_d;
    end

    assign out_flags = v_q[STAGES-1] ? flags_q[STAGES-1] : 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            v_q <= '0;
        else
            v_q <= v_d;
    end

    always_ff @(posedge clk) begin
        sign_p0_q  <= sign_p0_d;
        rnd_p0_q   <= rnd_p0_d;
        kind_p0_q  <= kind_p0_d;
        exp_p0_q   <= exp_p0_d;
        man_a_p0_q <= man_a_p0_d;
        man_b_p0_q <= man_b_p0_d;
        sign_p1_q  <= sign_p1_d;
        rnd_p1_q   <= rnd_p1_d;
        kind_p1_q  <= kind_p1_d;
        exp_p1_q   <= exp_p1_d;
        prod_p1_q  <= prod_p1_d;
        res_q      <= res_d;
    end

    assign out_valid  = v_q[STAGES-1];
    assign out_result = v_q[STAGES-1] ? res_q[STAGES-1] : '0;

endmodule

// File: tb/tb_fpu_mult_stream.sv
// Directed bench: FP16/FP32 vectors, latency, reset mid-stream and STAGES=5 backpressure.
module tb_fpu_mult_stream;

    typedef struct {
        string       tag;
        bit          wide;
        logic [31:0] a;
        logic [31:0] b;
        logic        rnd;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst = 1'b1, in_valid = 1'b0, in_rnd = 1'b0, ordy = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, r16;
    logic [31:0] a32 = '0, b32 = '0, r32;
    logic        rdy16, rdy32, ov16, ov32;

    logic        v5 = 1'b0, ordy5 = 1'b1, rdy5, ov5;
    logic [15:0] a5 = '0, b5 = 16'h4000, r5;
    logic [15:0] got[$];

`ifdef FPU_MULT_FLAGS_EN
    logic [3:0]  f16, f32, f5;
`endif

    vec_t vecs[18];

    fpu_mult_stream #(.EXP_W(5), .MAN_W(10), .STAGES(3)) u_fp16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(a16), .in_b(b16), .in_rnd(in_rnd),
        .out_valid(ov16), .out_ready(ordy),
`ifdef FPU_MULT_FLAGS_EN
        .out_flags(f16),
`endif
        .out_result(r16)
    );

    fpu_mult_stream #(.EXP_W(8), .MAN_W(23), .STAGES(3)) u_fp32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(a32), .in_b(b32), .in_rnd(in_rnd),
        .out_valid(ov32), .out_ready(ordy),
`ifdef FPU_MULT_FLAGS_EN
        .out_flags(f32),
`endif
        .out_result(r32)
    );

    fpu_mult_stream #(.EXP_W(5), .MAN_W(10), .STAGES(5)) u_fp16_s5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5),
        .in_a(a5), .in_b(b5), .in_rnd(in_rnd),
        .out_valid(ov5), .out_ready(ordy5),
`ifdef FPU_MULT_FLAGS_EN
        .out_flags(f5),
`endif
        .out_result(r5)
    );

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        a16 = v.a[15:0];
        b16 = v.b[15:0];
        a32 = v.a;
        b32 = v.b;
        in_rnd = v.rnd;
        in_valid = 1'b1;
        #1;
        check({v.tag, "_ready"}, {63'd0, (v.wide ? rdy32 : rdy16)}, 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(v.wide ? ov32 : ov16) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({v.tag, "_lat"}, 64'(lat), 64'd3);
        check(v.tag, v.wide ? {32'd0, r32} : {48'd0, r16}, {32'd0, v.res});
`ifdef FPU_MULT_FLAGS_EN
        check({v.tag, "_flags"}, {60'd0, (v.wide ? f32 : f16)}, {60'd0, v.flg});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stale;
        bit take_in;

        vecs[0]  = '{"h_1p5x2",     1'b0, 32'h3E00, 32'h4000, 1'b0, 32'h4200, 4'h0};
        vecs[1]  = '{"h_tie_rne",   1'b0, 32'h3C01, 32'h3E00, 1'b0, 32'h3E02, 4'h1};
        vecs[2]  = '{"h_tie_rtz",   1'b0, 32'h3C01, 32'h3E00, 1'b1, 32'h3E01, 4'h1};
        vecs[3]  = '{"h_ovf_rne",   1'b0, 32'h7BFF, 32'h4000, 1'b0, 32'h7C00, 4'h5};
        vecs[4]  = '{"h_ovf_rtz",   1'b0, 32'h7BFF, 32'h4000, 1'b1, 32'h7BFF, 4'h5};
        vecs[5]  = '{"h_unf",       1'b0, 32'h0400, 32'h3800, 1'b0, 32'h0000, 4'h3};
        vecs[6]  = '{"h_inf_x_0",   1'b0, 32'h7C00, 32'h0000, 1'b0, 32'h7E00, 4'h8};
        vecs[7]  = '{"h_ninf_x2",   1'b0, 32'hFC00, 32'h4000, 1'b0, 32'hFC00, 4'h0};
        vecs[8]  = '{"h_sub_ftz",   1'b0, 32'h0001, 32'h4000, 1'b0, 32'h0000, 4'h0};
        vecs[9]  = '{"h_negzero",   1'b0, 32'h8000, 32'h3C00, 1'b0, 32'h8000, 4'h0};
        vecs[10] = '{"s_1p5x2",     1'b1, 32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'h0};
        vecs[11] = '{"s_tie_rne",   1'b1, 32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'h1};
        vecs[12] = '{"s_tie_rtz",   1'b1, 32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'h1};
        vecs[13] = '{"s_ovf_rne",   1'b1, 32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'h5};
        vecs[14] = '{"s_ovf_rtz",   1'b1, 32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'h5};
        vecs[15] = '{"s_unf",       1'b1, 32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'h3};
        vecs[16] = '{"s_inf_x_0",   1'b1, 32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[17] = '{"s_ninf_x2",   1'b1, 32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, ov16}, 64'd0);
        check("rst_out_result", {48'd0, r16}, 64'd0);
        check("rst_in_ready", {63'd0, rdy16}, 64'd1);
        check("rst_s5_valid", {63'd0, ov5}, 64'd0);
        check("rst_s5_ready", {63'd0, rdy5}, 64'd1);

        for (int i = 0; i < 18; i++)
            run_vec(vecs[i]);

        // Reset with three operations in flight.
        @(negedge clk);
        a16 = 16'h3E00;
        b16 = 16'h4000;
        in_rnd = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_full", {63'd0, ov16}, 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", {63'd0, ov16}, 64'd0);
        check("midrst_result", {48'd0, r16}, 64'd0);
        check("midrst_ready", {63'd0, rdy16}, 64'd1);
        rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (ov16) stale++;
        end
        check("midrst_stale", 64'(stale), 64'd0);

        // STAGES=5 stalled fill with one bubble injected after two accepts.
        ordy5 = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc == 2) begin
                v5 = 1'b0;
            end else begin
                v5 = 1'b1;
                a5 = 16'h3C00 + 16'(acc);
            end
            #1;
            take_in = v5 && rdy5;
            @(posedge clk);
            if (take_in) acc++;
            @(negedge clk);
        end
        #1;
        check("bp_accepts", 64'(acc), 64'd5);
        check("bp_ready_low", {63'd0, rdy5}, 64'd0);
        check("bp_head_valid", {63'd0, ov5}, 64'd1);
        check("bp_head_result", {48'd0, r5}, 64'h4000);

        // Random out_ready drain while the remaining three ops are fed in.
        for (int cyc = 0; cyc < 300 && got.size() < 8; cyc++) begin
            ordy5 = 1'($urandom_range(0, 1));
            if (acc < 8) begin
                v5 = 1'b1;
                a5 = 16'h3C00 + 16'(acc);
            end else begin
                v5 = 1'b0;
            end
            #1;
            take_in = v5 && rdy5;
            if (ov5 && ordy5) got.push_back(r5);
            @(posedge clk);
            if (take_in) acc++;
            @(negedge clk);
        end
        check("bp_result_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("bp_order_%0d", i), {48'd0, got[i]}, 64'h4000 + 64'(i));

        v5 = 1'b0;
        ordy5 = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (ov5) stale++;
        end
        check("bp_no_duplicate", 64'(stale), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
